// File: rtl/signed_mult_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed array multiplier among N_REQ requesters.
// The product and the requester ID are held in a one-entry result register with a valid/ready handshake.
module signed_mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [8:0]         rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               can_accept_s;
    logic               win_found_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               accept_s;
    logic [3:0]         win_a_s;
    logic [3:0]         win_b_s;
    logic [8:0]         product_s;
    logic               rsp_fire_s;

    // Modular add on the requester ring; base < N_REQ and offs <= N_REQ, so one wrap suffices.
    function automatic logic [ID_W-1:0] ring_add(input logic [ID_W-1:0] base, input logic [ID_W:0] offs);
        logic [ID_W+1:0] sum;
        sum = {2'b00, base} + {1'b0, offs};
        if (sum >= (ID_W+2)'(N_REQ)) begin
            sum = sum - (ID_W+2)'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // Shift-add array of partial products; the MSB row of B carries negative weight.
    function automatic logic [8:0] mult4s(input logic [3:0] a, input logic [3:0] b);
        logic [8:0] a_ext;
        logic [8:0] acc;
        a_ext = {{5{a[3]}}, a};
        acc   = 9'd0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) begin
                acc = acc + (a_ext << i);
            end else begin
                acc = acc;
            end
        end
        if (b[3]) begin
            acc = acc - (a_ext << 3);
        end else begin
            acc = acc;
        end
        return acc;
    endfunction

    // Round-robin search for the first valid requester starting at rr_ptr_q.
    always_comb begin
        logic [ID_W-1:0] cand;
        win_found_s = 1'b0;
        win_idx_s   = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand = ring_add(rr_ptr_q, (ID_W+1)'(k));
            if (!win_found_s && req_valid[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand;
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Grant generation and operand mux into the multiplier.
    always_comb begin
        can_accept_s = (state_q == ST_EMPTY) | rsp_ready;
        accept_s     = win_found_s & can_accept_s & ~rst;
        req_ready    = {N_REQ{1'b0}};
        if (accept_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        win_a_s   = req_a[{win_idx_s, 2'b00} +: 4];
        win_b_s   = req_b[{win_idx_s, 2'b00} +: 4];
        product_s = mult4s(win_a_s, win_b_s);
    end

    // Next state of the result register FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !accept_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // FSM outputs.
    always_comb begin
        case (state_q)
            ST_EMPTY: rsp_valid = 1'b0;
            ST_FULL:  rsp_valid = 1'b1;
            default:  rsp_valid = 1'b0;
        endcase
        rsp_data = rsp_data_q;
        rsp_id   = rsp_id_q;
        op_count = op_count_q;
    end

    // Next values for pointer, result payload and the saturating handshake counter.
    always_comb begin
        rsp_fire_s = (state_q == ST_FULL) & rsp_ready;
        if (accept_s) begin
            rsp_data_d = product_s;
            rsp_id_d   = win_idx_s;
            rr_ptr_d   = ring_add(win_idx_s, {{ID_W{1'b0}}, 1'b1});
        end else begin
            rsp_data_d = rsp_data_q;
            rsp_id_d   = rsp_id_q;
            rr_ptr_d   = rr_ptr_q;
        end
        if (rsp_fire_s && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            op_count_d = op_count_q;
        end
    end

    // State register; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= {ID_W{1'b0}};
            rsp_data_q <= 9'd0;
            rsp_id_q   <= {ID_W{1'b0}};
            op_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Randomized bench for signed_mult_arbiter against an integer reference model of the arbiter and result stage.
// A second instance with a 3-bit counter shares the stimulus to exercise counter saturation.
module tb_signed_mult_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    logic [3:0]  sat_req_ready;
    logic        sat_rsp_valid;
    logic [8:0]  sat_rsp_data;
    logic [1:0]  sat_rsp_id;
    logic [2:0]  op_count_sat;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_hs    = 0;

    always #5 clk = ~clk;

    signed_mult_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .op_count(op_count)
    );

    signed_mult_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(sat_req_ready), .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(sat_rsp_data), .rsp_id(sat_rsp_id), .op_count(op_count_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx4(input logic [3:0] x);
        return x[3] ? int'(x) - 16 : int'(x);
    endfunction

    function automatic int find_winner(input logic [3:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock: check grant mid-cycle, advance the model at the edge, check outputs just after.
    task automatic step();
        int w;
        int acc_w;
        logic [3:0] exp_rdy;
        logic [3:0] a;
        logic [3:0] b;
        bit rdy;
        @(negedge clk);
        rdy = rsp_ready;
        w = find_winner(req_valid, m_ptr);
        exp_rdy = 4'b0000;
        acc_w = -1;
        if (!rst && (!m_valid || rdy) && w >= 0) begin
            exp_rdy[w] = 1'b1;
            acc_w = w;
            a = req_a[4*w +: 4];
            b = req_b[4*w +: 4];
        end
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = 0; m_hs = 0;
        end else begin
            if (m_valid && rdy) m_hs++;
            if (acc_w >= 0) begin
                m_valid = 1'b1;
                m_data  = (sx4(a) * sx4(b)) & 511;
                m_id    = acc_w;
                m_ptr   = (acc_w + 1) % N;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", rsp_id, m_id);
        chk("op_count", op_count, min_i(m_hs, 65535));
        chk("op_count_sat", op_count_sat, min_i(m_hs, 7));
    endtask

    logic [3:0] ca [4];
    logic [3:0] cb [4];
    logic [8:0] cexp [4];
    logic [8:0] hold_d;
    logic [1:0] hold_id;

    initial begin
        ca   = '{4'h8, 4'h8, 4'hF, 4'h0};
        cb   = '{4'h8, 4'h7, 4'h1, 4'h8};
        cexp = '{9'h040, 9'h1C8, 9'h1FF, 9'h000};

        rst = 1'b1; req_valid = 4'b0000; req_a = 16'h0000; req_b = 16'h0000; rsp_ready = 1'b0;
        step();
        step();
        chk("reset_valid", rsp_valid, 1'b0);
        chk("reset_count", op_count, 16'd0);
        rst = 1'b0;

        // Single request from requester 2: 3*5
        rsp_ready = 1'b1;
        req_valid = 4'b0100; req_a[11:8] = 4'd3; req_b[11:8] = 4'd5;
        step();
        chk("t1_data", rsp_data, 9'h00F);
        chk("t1_id", rsp_id, 2'd2);
        req_valid = 4'b0000;
        step();
        chk("t1_count", op_count, 16'd1);

        // Signed corner products through requester 0
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001; req_a[3:0] = ca[i]; req_b[3:0] = cb[i];
            step();
            chk("t2_corner", rsp_data, cexp[i]);
        end
        req_valid = 4'b0000;
        step();

        // All requesters valid, consumer always ready
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            req_a = 16'($urandom); req_b = 16'($urandom);
            step();
            chk("t3_no_gap", rsp_valid, 1'b1);
        end

        // Consumer stalls for 5 cycles
        rsp_ready = 1'b0;
        hold_d = rsp_data; hold_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_data", rsp_data, hold_d);
            chk("t4_hold_id", rsp_id, hold_id);
            chk("t4_no_grant", req_ready, 4'b0000);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t6_sat", op_count_sat, 3'd7);

        // Reset while full and stalled
        rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t5_valid", rsp_valid, 1'b0);
        chk("t5_count", op_count, 16'd0);
        rst = 1'b0;
        req_valid = 4'b1010; rsp_ready = 1'b1;
        step();
        chk("t5_first_id", rsp_id, 2'd1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            req_valid = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
